alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU. Directly downstream of the ALU control decoder; consumes its 4-bit ALU control code plus the two operands and shift amount from the ID/EX register.
- Single-cycle ops return in one clock. MUL (code 4'b0011) runs an iterative radix-2 shift-add sequence and holds busy_o so the hazard unit stalls the pipeline.
- Registered result and zero flag feed the EX/MEM register and the branch logic.

Parameters:
- DATA_W, 32, operand/result width. LUI shifts by DATA_W/2; MUL iterates DATA_W times.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- valid_i  input  1  operation request; sampled only when busy_o=0.
- flush_i  input  1  synchronous abort of any in-flight operation.
- alu_ctrl_i  input  4  operation code from the ALU control decoder.
- src1_i  input  DATA_W  operand A (rs).
- src2_i  input  DATA_W  operand B (rt or immediate).
- shamt_i  input  5  shift amount (instr[10:6] for SRA, rs[4:0] for SRAV; muxed upstream).
- result_o  output  DATA_W  registered result.
- zero_o  output  1  registered; 1 when the result written is all zeros.
- done_o  output  1  one-cycle pulse; result_o/zero_o updated on the same edge.
- busy_o  output  1  1 while a MUL is in progress.

Behaviour:
- Reset (rst_i=0, async): state=IDLE; result_o=0, zero_o=1, done_o=0, busy_o=0, counter=0, internal accumulator/multiplicand/multiplier=0.
- States: IDLE, MUL.
- IDLE, valid_i=1, code != 0011: on that edge, result_o=op(src1,src2) and done_o=1; state stays IDLE. Latency 1.
- Code map:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (src1-src2).
  - 0111 signed src1<src2 -> 1 else 0.
  - 1111 signed src1<=src2 -> 1 else 0.
  - 1110 LUI: src2<<(DATA_W/2).
  - 1010 SRA: src2 >>> shamt_i, arithmetic.
  - Any other code: result 0, done_o still pulses.
  - ADD/SUB wrap modulo 2^DATA_W; no overflow output.
- IDLE, valid_i=1, code=0011: on that edge, latch multiplicand=src1, multiplier=src2, acc=0, counter=0; state->MUL; busy_o=1; done_o=0; result_o holds its previous value.
- Each MUL edge:
  - If multiplier[0]=1, acc += multiplicand.
  - Then multiplicand <<=1, multiplier >>=1 (logical), counter++.
  - On the edge where counter reaches DATA_W-1: result_o = final acc (low DATA_W bits), zero_o updated, done_o=1, busy_o=0, state->IDLE.
  - Total: accept edge k -> done on edge k+DATA_W (32 for default). Result is the signed/unsigned-agnostic low word.
- valid_i while busy_o=1: ignored, not queued. Upstream must hold the request until busy_o=0.
- valid_i in the cycle done_o=1: accepted normally; back-to-back issue is allowed.
- flush_i=1: overrides valid_i on the same edge. State->IDLE, busy_o=0, done_o=0, result_o/zero_o unchanged, partial product discarded.
- IDLE, valid_i=0: done_o=0, all outputs hold.
- Reset asserted mid-MUL: immediate return to reset values; no done_o.

Test Plan:
- Reset, then ADD src1=5 src2=7 -> next edge result_o=12, zero_o=0, done_o pulses 1 cycle, busy_o stays 0.
- SUB 9-9 then SLT 0xFFFFFFFF,1 then LE 3,3 -> results 0 (zero_o=1), 1, 1 on consecutive edges.
- SRA src2=0x80000010 shamt=4 -> 0xF8000001; LUI src2=0x1234 -> 0x12340000; undefined code 0101 -> 0 with done_o pulse.
- MUL 0x0000FFFF*0x00010001 -> busy_o high exactly 32 cycles; done_o at accept+32; result_o=0xFFFFFFFF. valid_i ADD held during busy is executed only after done.
- MUL -3*7 (0xFFFFFFFD, 7) -> 0xFFFFFFEB. Flush at cycle 10 of a second MUL -> busy_o drops next edge, no done_o, result_o stays 0xFFFFFFEB.
- rst_i pulsed low mid-MUL, asynchronous to clk -> outputs reset immediately; subsequent ADD 1+1 -> 2 after one cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU. Single-cycle operations (logic, add/sub, signed compares,
// LUI, arithmetic shift) complete on the accepting edge. MUL (code 4'b0011)
// runs an iterative radix-2 shift-add over DATA_W edges and holds busy_o so
// the hazard unit can stall the pipeline.
//
// Ports:
//   clk_i       in   rising-edge clock
//   rst_i       in   asynchronous active-low reset
//   valid_i     in   operation request, sampled only while busy_o = 0
//   flush_i     in   synchronous abort of any in-flight operation
//   alu_ctrl_i  in   [3:0] operation code from the ALU control decoder
//   src1_i      in   [DATA_W-1:0] operand A (rs)
//   src2_i      in   [DATA_W-1:0] operand B (rt or immediate)
//   shamt_i     in   [4:0] shift amount for SRA/SRAV
//   result_o    out  [DATA_W-1:0] registered result
//   zero_o      out  registered, 1 when the last written result is all zeros
//   done_o      out  one-cycle pulse, coincident with result_o/zero_o update
//   busy_o      out  1 while a MUL is in progress
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [3:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_LUI = 4'b1110;
  localparam logic [3:0] OP_SLE = 4'b1111;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [DATA_W-1:0] mcand, mcand_nxt;
  logic [DATA_W-1:0] mplier, mplier_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] result_nxt;
  logic              zero_nxt;
  logic              done_nxt;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] acc_sum;

  // Single-cycle operation result.
  always_comb begin
    alu_res = '0;
    unique case (alu_ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) <  $signed(src2_i))};
      OP_SLE:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) <= $signed(src2_i))};
      OP_LUI:  alu_res = src2_i << (DATA_W / 2);
      OP_SRA:  alu_res = $signed(src2_i) >>> shamt_i;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;
    result_nxt = result_o;
    zero_nxt   = zero_o;
    done_nxt   = 1'b0;

    if (flush_i) begin
      // Abort: drop any partial product, keep the last written result visible.
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (alu_ctrl_i == OP_MUL) begin
              mcand_nxt  = src1_i;
              mplier_nxt = src2_i;
              acc_nxt    = '0;
              cnt_nxt    = '0;
              state_nxt  = S_MUL;
            end else begin
              result_nxt = alu_res;
              zero_nxt   = (alu_res == '0);
              done_nxt   = 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_nxt    = acc_sum;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          cnt_nxt    = cnt + CNT_W'(1);
          // The counter holds the index of the step being performed, so the
          // step with index DATA_W-1 is the last one and its sum is final.
          if (cnt == LAST_ITER) begin
            result_nxt = acc_sum;
            zero_nxt   = (acc_sum == '0);
            done_nxt   = 1'b1;
            state_nxt  = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values and ordering between statements is irrelevant.
  // NOTE: the multiplier datapath registers are reset as well; there are only a
  // few of them and a known value after reset keeps the outputs deterministic.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_o <= '0;
      zero_o   <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      cnt      <= cnt_nxt;
      result_o <= result_nxt;
      zero_o   <= zero_nxt;
      done_o   <= done_nxt;
    end
  end

  // Direct decode of the state flop, so busy_o is glitch-free.
  assign busy_o = (state == S_MUL);

endmodule
